// File: rtl/pc_seq_if.sv
// Instruction-memory fetch bus: pc_seq drives req/addr and the memory answers with gnt, rvalid and rdata.
interface pc_seq_if #(
   parameter int WORD_SIZE = 32
);
   logic                 req;
   logic [WORD_SIZE-1:0] addr;
   logic                 gnt;
   logic                 rvalid;
   logic [WORD_SIZE-1:0] rdata;

   modport master (output req, addr, input gnt, rvalid, rdata);
   modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/pc_seq.sv
// Fetch sequencer: owns the PC, runs the imem req/gnt/rvalid handshake and feeds the IF/ID buffer.
module pc_seq #(
   parameter int                   WORD_SIZE = 32,
   parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 stall_i,
   input  logic                 br_taken_i,
   input  logic [WORD_SIZE-1:0] br_target_i,
   input  logic                 jmp_valid_i,
   input  logic [WORD_SIZE-1:0] jmp_target_i,
   input  logic                 halt_req_i,
   pc_seq_if.master             imem,
   output logic [WORD_SIZE-1:0] pc_o,
   output logic                 if_valid_o,
   output logic [WORD_SIZE-1:0] if_pc_o,
   output logic [WORD_SIZE-1:0] if_instr_o,
   output logic                 halted_o,
   output logic [31:0]          cycles_o
);

   typedef enum logic [2:0] {IDLE, REQ, RESP, DRAIN, HALT} state_e;

   state_e               state_q;
   logic [WORD_SIZE-1:0] pc_q;
   logic [WORD_SIZE-1:0] reqAddr_q;
   logic                 drop_q;
   logic                 ifValid_q;
   logic [WORD_SIZE-1:0] ifPc_q;
   logic [WORD_SIZE-1:0] ifInstr_q;
   logic [31:0]          cycles_q;
   logic [31:0]          cycles_d;

   logic                 redirect;
   logic [WORD_SIZE-1:0] redirTarget;
   logic                 consumed;
   logic                 fetchAccepted;

   // Branch resolves in EX, so it is older than a jump decoded in ID and takes priority.
   assign redirect      = br_taken_i | jmp_valid_i;
   assign redirTarget   = br_taken_i ? br_target_i : jmp_target_i;
   assign consumed      = ifValid_q & ~stall_i;
   assign fetchAccepted = imem.req & imem.gnt;

   // A request only goes out when the buffer has room; a halt that is not overridden suppresses it.
   assign imem.req  = (state_q == REQ) && (!ifValid_q || !stall_i) && (redirect || !halt_req_i);
   assign imem.addr = pc_q;

   assign cycles_d = (state_q != HALT && cycles_q != 32'hFFFF_FFFF) ? cycles_q + 32'd1 : cycles_q;

   assign pc_o       = pc_q;
   assign if_valid_o = ifValid_q;
   assign if_pc_o    = ifPc_q;
   assign if_instr_o = ifInstr_q;
   assign halted_o   = (state_q == HALT);
   assign cycles_o   = cycles_q;

   // Single state machine; later assignments to ifValid_q override the consume-clear at the top.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         reqAddr_q <= '0;
         drop_q    <= 1'b0;
         ifValid_q <= 1'b0;
         ifPc_q    <= '0;
         ifInstr_q <= '0;
         cycles_q  <= 32'd0;
      end else begin
         cycles_q <= cycles_d;
         if (consumed) ifValid_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (redirect) begin
                  pc_q      <= redirTarget;
                  ifValid_q <= 1'b0;
                  state_q   <= REQ;
               end else if (halt_req_i) begin
                  ifValid_q <= 1'b0;
                  state_q   <= HALT;
               end else begin
                  state_q <= REQ;
               end
            end
            REQ: begin
               if (redirect) begin
                  pc_q      <= redirTarget;
                  ifValid_q <= 1'b0;
                  if (fetchAccepted) begin
                     reqAddr_q <= pc_q;
                     drop_q    <= 1'b1;
                     state_q   <= RESP;
                  end
               end else if (halt_req_i) begin
                  ifValid_q <= 1'b0;
                  state_q   <= HALT;
               end else if (fetchAccepted) begin
                  reqAddr_q <= pc_q;
                  state_q   <= RESP;
               end
            end
            RESP: begin
               if (redirect) begin
                  pc_q      <= redirTarget;
                  ifValid_q <= 1'b0;
                  if (imem.rvalid) begin
                     drop_q  <= 1'b0;
                     state_q <= REQ;
                  end else begin
                     drop_q <= 1'b1;
                  end
               end else if (halt_req_i) begin
                  ifValid_q <= 1'b0;
                  drop_q    <= 1'b0;
                  state_q   <= imem.rvalid ? HALT : DRAIN;
               end else if (imem.rvalid) begin
                  state_q <= REQ;
                  if (drop_q) begin
                     drop_q <= 1'b0;
                  end else begin
                     ifValid_q <= 1'b1;
                     ifPc_q    <= reqAddr_q;
                     ifInstr_q <= imem.rdata;
                     pc_q      <= pc_q + WORD_SIZE'(1);
                  end
               end
            end
            DRAIN: begin
               if (redirect) begin
                  pc_q      <= redirTarget;
                  ifValid_q <= 1'b0;
               end
               if (imem.rvalid) begin
                  drop_q  <= 1'b0;
                  state_q <= HALT;
               end
            end
            HALT: begin
               state_q <= HALT;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_seq.sv
// Directed and randomised bench for pc_seq: a memory model answers fetches with addr+0x100 and a
// program-order scoreboard checks every instruction that ID consumes.
module tb_pc_seq;

   localparam int          WS        = 32;
   localparam logic [31:0] INSTR_OFS = 32'h100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        stall, brTaken, jmpValid, haltReq;
   logic [31:0] brTarget, jmpTarget;
   logic [31:0] pc, ifPc, ifInstr, cycles;
   logic        ifValid, halted;

   pc_seq_if #(.WORD_SIZE(WS)) imemBus ();

   pc_seq #(.WORD_SIZE(WS), .RESET_PC(32'h0)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall_i      (stall),
      .br_taken_i   (brTaken),
      .br_target_i  (brTarget),
      .jmp_valid_i  (jmpValid),
      .jmp_target_i (jmpTarget),
      .halt_req_i   (haltReq),
      .imem         (imemBus),
      .pc_o         (pc),
      .if_valid_o   (ifValid),
      .if_pc_o      (ifPc),
      .if_instr_o   (ifInstr),
      .halted_o     (halted),
      .cycles_o     (cycles)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   int          gntMode;
   int          delayMin, delayMax;
   bit          memBusy, strayRvalid;
   int          memWait;
   logic [31:0] memAddr;
   logic [31:0] nextPc;
   int unsigned expCycles;
   bit          expHalted;
   bit          prevPending;
   logic [31:0] prevAddr;
   bit          lastReq, lastGrant;
   logic [31:0] lastAddr;
   int          consumedCount;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // One clock cycle: drive inputs and memory, check the cycle, then advance to just after the next edge.
   task automatic applyStimulus(input bit st, input bit br, input logic [31:0] brT,
                                input bit jmp, input logic [31:0] jmpT, input bit hlt);
      bit redirect, gntNow, rvalidNow;
      stall     = st;
      brTaken   = br;
      brTarget  = brT;
      jmpValid  = jmp;
      jmpTarget = jmpT;
      haltReq   = hlt;
      rvalidNow = (memBusy && memWait == 0) || strayRvalid;
      imemBus.rvalid = rvalidNow;
      imemBus.rdata  = memBusy ? memAddr + INSTR_OFS : $urandom();
      gntNow = (gntMode == 1) || (gntMode == 2 && $urandom_range(0, 1) == 1);
      imemBus.gnt = gntNow;
      #1;
      lastReq   = imemBus.req;
      lastAddr  = imemBus.addr;
      lastGrant = lastReq && gntNow;
      redirect  = br || jmp;

      checkOutput("cycles", cycles, expCycles);
      if (memBusy) checkOutput("reqWhileOutstanding", {31'b0, imemBus.req}, 32'd0);
      if (prevPending && !hlt) begin
         checkOutput("reqHeld", {31'b0, imemBus.req}, 32'd1);
         checkOutput("addrHeld", imemBus.addr, prevAddr);
      end
      if (redirect && !expHalted) begin
         nextPc = br ? brT : jmpT;
      end else if (!hlt && ifValid && !st) begin
         checkOutput("ifPc", ifPc, nextPc);
         checkOutput("ifInstr", ifInstr, nextPc + INSTR_OFS);
         nextPc = nextPc + 32'd1;
         consumedCount++;
      end
      prevPending = lastReq && !gntNow && !redirect && !hlt;
      prevAddr    = lastAddr;

      if (rvalidNow) memBusy = 1'b0;
      if (lastGrant) begin
         memBusy = 1'b1;
         memAddr = lastAddr;
         memWait = $urandom_range(delayMax, delayMin);
      end else if (memBusy) begin
         memWait--;
      end
      strayRvalid = 1'b0;

      @(posedge clk);
      #1;
      if (!expHalted) expCycles++;
   endtask

   task automatic doReset();
      rst_n    = 1'b0;
      stall    = 1'b0;
      brTaken  = 1'b0;
      jmpValid = 1'b0;
      haltReq  = 1'b0;
      brTarget = '0;
      jmpTarget = '0;
      imemBus.gnt    = 1'b0;
      imemBus.rvalid = 1'b0;
      imemBus.rdata  = '0;
      memBusy = 1'b0;
      memWait = 0;
      prevPending = 1'b0;
      nextPc = 32'h0;
      expCycles = 0;
      expHalted = 1'b0;
      #1;
      checkOutput("rstPc", pc, 32'h0);
      checkOutput("rstReq", {31'b0, imemBus.req}, 32'd0);
      checkOutput("rstValid", {31'b0, ifValid}, 32'd0);
      checkOutput("rstIfPc", ifPc, 32'h0);
      checkOutput("rstIfInstr", ifInstr, 32'h0);
      checkOutput("rstHalted", {31'b0, halted}, 32'd0);
      checkOutput("rstCycles", cycles, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          n, r;
      logic [31:0] brT, jmpT;
      gntMode = 1;
      delayMin = 0;
      delayMax = 0;
      strayRvalid = 1'b0;
      consumedCount = 0;
      #1;
      doReset();

      // Back-to-back fetches: IDLE for one cycle, then one request every two cycles.
      for (int k = 0; k < 9; k++) begin
         applyStimulus(0, 0, 0, 0, 0, 0);
         checkOutput("seqReq", {31'b0, lastReq}, (k % 2 == 1) ? 32'd1 : 32'd0);
         if (k % 2 == 1) checkOutput("seqAddr", lastAddr, 32'((k - 1) / 2));
      end

      // Stall while instruction 4 sits in the buffer.
      n = 0;
      while (!(ifValid && ifPc == 32'd4) && n < 40) begin
         applyStimulus(0, 0, 0, 0, 0, 0);
         n++;
      end
      checkOutput("reachPc4", {31'b0, ifValid && ifPc == 32'd4}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1, 0, 0, 0, 0, 0);
         checkOutput("stallValid", {31'b0, ifValid}, 32'd1);
         checkOutput("stallPc", ifPc, 32'd4);
         checkOutput("stallInstr", ifInstr, 32'h104);
         checkOutput("stallNoReq", {31'b0, lastReq}, 32'd0);
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("resumeReq", {31'b0, lastReq}, 32'd1);
      checkOutput("resumeAddr", lastAddr, 32'd5);

      // Branch to 0x40 while the fetch of 7 is outstanding.
      delayMin = 2;
      delayMax = 2;
      n = 0;
      do begin
         applyStimulus(0, 0, 0, 0, 0, 0);
         n++;
      end while (!(lastGrant && lastAddr == 32'd7) && n < 40);
      checkOutput("grant7", {31'b0, lastGrant && lastAddr == 32'd7}, 32'd1);
      applyStimulus(0, 1, 32'h40, 0, 0, 0);
      n = 0;
      while (!lastReq && n < 10) begin
         checkOutput("dropValid", {31'b0, ifValid}, 32'd0);
         applyStimulus(0, 0, 0, 0, 0, 0);
         n++;
      end
      checkOutput("brReqSeen", {31'b0, lastReq}, 32'd1);
      checkOutput("brTargetAddr", lastAddr, 32'h40);

      // Branch and jump together; then hold gnt low and watch the request stay put.
      gntMode = 0;
      delayMin = 0;
      delayMax = 0;
      applyStimulus(0, 1, 32'h10, 1, 32'h20, 0);
      n = 0;
      while (!lastReq && n < 10) begin
         applyStimulus(0, 0, 0, 0, 0, 0);
         n++;
      end
      checkOutput("brWinsReq", {31'b0, lastReq}, 32'd1);
      checkOutput("brWinsAddr", lastAddr, 32'h10);
      for (int k = 0; k < 5; k++) begin
         applyStimulus(0, 0, 0, 0, 0, 0);
         checkOutput("gntLowReq", {31'b0, lastReq}, 32'd1);
         checkOutput("gntLowAddr", lastAddr, 32'h10);
      end

      // Halt with the fetch of 0x10 outstanding: drain, then freeze.
      gntMode = 1;
      delayMin = 2;
      delayMax = 2;
      n = 0;
      do begin
         applyStimulus(0, 0, 0, 0, 0, 0);
         n++;
      end while (!lastGrant && n < 10);
      checkOutput("haltFetchAddr", lastAddr, 32'h10);
      applyStimulus(0, 0, 0, 0, 0, 1);
      n = 0;
      while (memBusy && n < 10) begin
         checkOutput("drainNotHalted", {31'b0, halted}, 32'd0);
         applyStimulus(0, 0, 0, 0, 0, 0);
         n++;
      end
      expHalted = 1'b1;
      checkOutput("haltedHigh", {31'b0, halted}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 1, 32'h55, 0, 0, 0);
         checkOutput("haltNoReq", {31'b0, lastReq}, 32'd0);
         checkOutput("haltValid", {31'b0, ifValid}, 32'd0);
         checkOutput("haltPc", pc, 32'h10);
         checkOutput("haltStays", {31'b0, halted}, 32'd1);
      end

      // Reset out of HALT; a stray rvalid in the IDLE cycle must be ignored.
      doReset();
      strayRvalid = 1'b1;

      // Randomised traffic: random gnt, response delay, stalls and redirects (some near the wrap point).
      gntMode = 2;
      delayMin = 0;
      delayMax = 2;
      consumedCount = 0;
      for (int k = 0; k < 400; k++) begin
         r    = $urandom_range(0, 99);
         brT  = (r < 2) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 255));
         jmpT = 32'($urandom_range(0, 255));
         applyStimulus($urandom_range(0, 3) == 0, r < 5, brT, r >= 3 && r < 9, jmpT, 0);
      end
      checkOutput("progress", {31'b0, consumedCount >= 30}, 32'd1);

      // Halt from REQ with nothing outstanding: halted on the very next cycle.
      n = 0;
      while (memBusy && n < 10) begin
         applyStimulus(0, 0, 0, 0, 0, 0);
         n++;
      end
      applyStimulus(0, 0, 0, 0, 0, 1);
      expHalted = 1'b1;
      checkOutput("haltReqNoReq", {31'b0, lastReq}, 32'd0);
      checkOutput("haltedNext", {31'b0, halted}, 32'd1);
      applyStimulus(0, 1, 32'h77, 0, 0, 0);
      checkOutput("haltedFrozen", {31'b0, halted}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
